// File: rtl/output_buffer_pkg.sv
// Shared address map, reset constants and byte-enable merge for the output buffer.
package output_buffer_pkg;

    localparam int unsigned ADDR_W = 16;

    localparam logic [ADDR_W-1:0] ADDR_LEDR         = 16'h7000;
    localparam logic [ADDR_W-1:0] ADDR_LEDG         = 16'h7010;
    localparam logic [ADDR_W-1:0] ADDR_HEX_LO       = 16'h7020;
    localparam logic [ADDR_W-1:0] ADDR_HEX_HI       = 16'h7024;
    localparam logic [ADDR_W-1:0] ADDR_LCD          = 16'h7030;
    localparam logic [ADDR_W-1:0] ADDR_BLINK_MASK   = 16'h7040;
    localparam logic [ADDR_W-1:0] ADDR_BLINK_PERIOD = 16'h7044;

    localparam logic [31:0] HEX_OFF = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        REG_NONE,
        REG_LEDR,
        REG_LEDG,
        REG_HEX_LO,
        REG_HEX_HI,
        REG_LCD,
        REG_BLINK_MASK,
        REG_BLINK_PERIOD
    } reg_sel_e;

    function automatic logic [31:0] byte_merge(
        input logic [31:0] old_word,
        input logic [31:0] new_word,
        input logic [3:0]  bmask
    );
        logic [31:0] result;
        result = old_word;
        for (int unsigned n = 0; n < 4; n++) begin
            if (bmask[n]) result[8*n +: 8] = new_word[8*n +: 8];
        end
        return result;
    endfunction

endpackage

// File: rtl/output_buffer_blink_timer.sv
// Blink prescaler: 24-bit down-counter that reloads from the period and toggles phase on expiry.
module output_buffer_blink_timer #(
    parameter logic [23:0] DEFAULT_PERIOD = 24'd50_000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_load,
    input  logic [23:0] i_load_value,
    input  logic [23:0] i_period,
    output logic        o_phase
);

    logic [23:0] count;

    // A period write restarts the cycle from phase 0 even if the counter expires on the same edge.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            count   <= DEFAULT_PERIOD;
            o_phase <= 1'b0;
        end else if (i_load) begin
            count   <= i_load_value;
            o_phase <= 1'b0;
        end else if (i_period == '0) begin
            count   <= '0;
            o_phase <= 1'b0;
        end else if (count == '0) begin
            count   <= i_period;
            o_phase <= ~o_phase;
        end else begin
            count   <= count - 24'd1;
        end
    end

endmodule

// File: rtl/output_buffer.sv
// Memory-mapped output registers (LEDs, seven-segment, LCD) with optional LEDR blink.
// Define OUTPUT_BUFFER_BLINK_EN to include the blink mask/period registers and timer.
module output_buffer
    import output_buffer_pkg::*;
#(
    parameter logic [23:0] DEFAULT_PERIOD = 24'd50_000
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_st_en,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [31:0]       i_st_data,
    input  logic [3:0]        i_bmask,
    output logic [31:0]       o_ld_data,
    output logic [31:0]       o_io_ledr,
    output logic [31:0]       o_io_ledg,
    output logic [6:0]        o_io_hex0,
    output logic [6:0]        o_io_hex1,
    output logic [6:0]        o_io_hex2,
    output logic [6:0]        o_io_hex3,
    output logic [6:0]        o_io_hex4,
    output logic [6:0]        o_io_hex5,
    output logic [6:0]        o_io_hex6,
    output logic [6:0]        o_io_hex7,
    output logic [31:0]       o_io_lcd
);

    reg_sel_e    sel;
    logic        wr_en;
    logic [31:0] cur_word;
    logic [31:0] merged;
    logic [31:0] ledr;
    logic [31:0] ledg;
    logic [31:0] hex_lo;
    logic [31:0] hex_hi;
    logic [31:0] lcd;
`ifdef OUTPUT_BUFFER_BLINK_EN
    logic [31:0] blink_mask;
    logic [23:0] blink_period;
    logic        phase;
`endif

    assign wr_en = i_st_en && (i_bmask != '0);

    always_comb begin
        sel = REG_NONE;
        case (i_addr[ADDR_W-1:2])
            ADDR_LEDR[ADDR_W-1:2]:         sel = REG_LEDR;
            ADDR_LEDG[ADDR_W-1:2]:         sel = REG_LEDG;
            ADDR_HEX_LO[ADDR_W-1:2]:       sel = REG_HEX_LO;
            ADDR_HEX_HI[ADDR_W-1:2]:       sel = REG_HEX_HI;
            ADDR_LCD[ADDR_W-1:2]:          sel = REG_LCD;
`ifdef OUTPUT_BUFFER_BLINK_EN
            ADDR_BLINK_MASK[ADDR_W-1:2]:   sel = REG_BLINK_MASK;
            ADDR_BLINK_PERIOD[ADDR_W-1:2]: sel = REG_BLINK_PERIOD;
`endif
            default:                       sel = REG_NONE;
        endcase
    end

    // The readback mux also feeds the byte merge, so partial writes keep unselected bytes.
    always_comb begin
        cur_word = '0;
        case (sel)
            REG_LEDR:         cur_word = ledr;
            REG_LEDG:         cur_word = ledg;
            REG_HEX_LO:       cur_word = hex_lo;
            REG_HEX_HI:       cur_word = hex_hi;
            REG_LCD:          cur_word = lcd;
`ifdef OUTPUT_BUFFER_BLINK_EN
            REG_BLINK_MASK:   cur_word = blink_mask;
            REG_BLINK_PERIOD: cur_word = {8'h00, blink_period};
`endif
            default:          cur_word = '0;
        endcase
    end

    assign merged    = byte_merge(cur_word, i_st_data, i_bmask);
    assign o_ld_data = cur_word;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            ledr         <= '0;
            ledg         <= '0;
            hex_lo       <= HEX_OFF;
            hex_hi       <= HEX_OFF;
            lcd          <= '0;
`ifdef OUTPUT_BUFFER_BLINK_EN
            blink_mask   <= '0;
            blink_period <= DEFAULT_PERIOD;
`endif
        end else if (wr_en) begin
            case (sel)
                REG_LEDR:         ledr         <= merged;
                REG_LEDG:         ledg         <= merged;
                REG_HEX_LO:       hex_lo       <= merged;
                REG_HEX_HI:       hex_hi       <= merged;
                REG_LCD:          lcd          <= merged;
`ifdef OUTPUT_BUFFER_BLINK_EN
                REG_BLINK_MASK:   blink_mask   <= merged;
                REG_BLINK_PERIOD: blink_period <= merged[23:0];
`endif
                default:          ;
            endcase
        end
    end

`ifdef OUTPUT_BUFFER_BLINK_EN
    output_buffer_blink_timer #(
        .DEFAULT_PERIOD(DEFAULT_PERIOD)
    ) blink_timer (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_load       (wr_en && (sel == REG_BLINK_PERIOD)),
        .i_load_value (merged[23:0]),
        .i_period     (blink_period),
        .o_phase      (phase)
    );

    assign o_io_ledr = phase ? (ledr & ~blink_mask) : ledr;

    logic unused_bits;
    assign unused_bits = ^{i_addr[1:0], merged[31:24]};
`else
    assign o_io_ledr = ledr;

    logic unused_bits;
    assign unused_bits = ^{i_addr[1:0], DEFAULT_PERIOD};
`endif

    assign o_io_ledg = ledg;
    assign o_io_lcd  = lcd;
    assign o_io_hex0 = hex_lo[6:0];
    assign o_io_hex1 = hex_lo[14:8];
    assign o_io_hex2 = hex_lo[22:16];
    assign o_io_hex3 = hex_lo[30:24];
    assign o_io_hex4 = hex_hi[6:0];
    assign o_io_hex5 = hex_hi[14:8];
    assign o_io_hex6 = hex_hi[22:16];
    assign o_io_hex7 = hex_hi[30:24];

endmodule

// File: doc/output_buffer.md
OUTPUT_BUFFER -- requirements
Module: output_buffer

Interface
REQ-001 Parameter DEFAULT_PERIOD, 24'd50_000, blink reload value loaded at reset.
REQ-002 i_clk  input  1  sole clock; all state updates on posedge.
REQ-003 i_reset  input  1  synchronous, active-high reset.
REQ-004 i_st_en  input  1  store strobe from LSU; one write per asserted cycle.
REQ-005 i_addr  input  16  byte address; bits [1:0] ignored.
REQ-006 i_st_data  input  32  store data.
REQ-007 i_bmask  input  4  byte enables; bit n enables byte [8n+7:8n].
REQ-008 o_ld_data  output  32  combinational readback of the addressed register.
REQ-009 o_io_ledr  output  32  red LEDs.
REQ-010 o_io_ledg  output  32  green LEDs.
REQ-011 o_io_hex0..o_io_hex7  output  7 each  seven-segment digits, active-low.
REQ-012 o_io_lcd  output  32  LCD control/data word.

Function
REQ-013 Address map: 0x7000 LEDR, 0x7010 LEDG, 0x7020 HEX0-3 (byte n -> HEXn), 0x7024 HEX4-7 (byte n -> HEX(4+n)), 0x7030 LCD, 0x7040 BLINK_MASK, 0x7044 BLINK_PERIOD (bits [23:0]).
REQ-014 Write with i_st_en=1 to a mapped address updates only bytes with i_bmask set, at the next posedge; other bytes hold.
REQ-015 Write to an unmapped address or with i_bmask=0 changes no state.
REQ-016 o_ld_data returns the stored register value, pre-blink; unmapped address returns 32'h0.
REQ-017 New write data is visible on outputs and o_ld_data the cycle after the write edge; no extra latency.
REQ-018 HEX digit n = bits [6:0] of its byte; bit 7 is stored and read back but not driven.
REQ-019 Blink counter: 24-bit down-counter; at 0 it reloads BLINK_PERIOD and toggles phase; otherwise it decrements.
REQ-020 Phase 1: o_io_ledr bits with BLINK_MASK=1 forced to 0; phase 0: o_io_ledr = stored LEDR.
REQ-021 BLINK_PERIOD=0: phase held at 0, counter held at 0.
REQ-022 Write to BLINK_PERIOD loads counter with the new value and clears phase in the same edge; this overrides a simultaneous expiry.
REQ-023 Blink affects only o_io_ledr; all other outputs are stored values.

Reset
REQ-024 i_reset=1 at a posedge: LEDR, LEDG, LCD, BLINK_MASK = 0; HEX registers = 32'hFFFF_FFFF (all segments off); BLINK_PERIOD = counter = DEFAULT_PERIOD; phase = 0.
REQ-025 Reset overrides a simultaneous store; a reset in mid-blink ends with phase 0 on the next cycle.
REQ-026 No asynchronous path from i_reset to any flop.

Configuration
REQ-027 Macro OUTPUT_BUFFER_BLINK_EN defined: blink registers, counter and masking present per REQ-019..023.
REQ-028 Macro undefined: no blink logic; 0x7040/0x7044 unmapped (writes ignored, reads 0); o_io_ledr = stored LEDR.

Structure
REQ-029 Shared package holds address constants (LEDR, LEDG, HEX_LO, HEX_HI, LCD, BLINK_MASK, BLINK_PERIOD), the 16-bit address width, and the HEX-off reset constant.
REQ-030 Byte-enable merge is a function in the package; blink prescaler is one sub-module, blink_timer (counter, reload, phase).

Verification
REQ-031 Reset, then read every address -> LEDR/LEDG/LCD=0, HEX reads 32'hFFFF_FFFF, o_io_hex0..7=7'h7F.
REQ-032 Store 32'hA5A5_1234 to 0x7000 with bmask 4'b0011, after prior 32'hFFFF_FFFF -> o_io_ledr=32'hFFFF_1234 next cycle.
REQ-033 Store 32'h4079_2430 to 0x7020, bmask 4'hF -> hex0=7'h30, hex1=7'h24, hex2=7'h79, hex3=7'h40; hex4..7 unchanged 7'h7F.
REQ-034 Store to 0x7050 and bmask-0 store to 0x7010 -> no output change; read 0x7050 = 0.
REQ-035 (BLINK_EN) LEDR=32'hFF, MASK=32'h0F, PERIOD=3 -> o_io_ledr alternates 32'hFF / 32'hF0 every 4 cycles; PERIOD=0 -> steady 32'hFF.
REQ-036 Assert i_reset for one cycle during phase 1 and simultaneously store to 0x7000 -> next cycle o_io_ledr=0, phase 0, LEDR read 0.
